// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter that sequences single reads/writes into a
// 128 x 8 SRAM register file and returns read data with a one-cycle ack.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   prefer_b;   // B wins a tie when set (A was served last)
  logic   owner_b;
  logic   owner_we;
  logic   grant_b_c;

  // Arbitration and next-state decode
  always_comb begin
    grant_b_c = b_req && (!a_req || prefer_b);
    state_nxt = state;
    case (state)
      IDLE:    if (a_req || b_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered outputs; the mem_* command registers double
  // as the latched address/data so they only move on the edge into ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prefer_b  <= 1'b0;
      owner_b   <= 1'b0;
      owner_we  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner_b   <= grant_b_c;
            owner_we  <= grant_b_c ? b_we : a_we;
            mem_raddr <= grant_b_c ? b_addr : a_addr;
            mem_waddr <= grant_b_c ? b_addr : a_addr;
            mem_wdata <= grant_b_c ? b_wdata : a_wdata;
            mem_we    <= grant_b_c ? b_we : a_we;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (!owner_we) begin
            if (owner_b) b_rdata <= mem_rdata;
            else         a_rdata <= mem_rdata;
          end
          if (owner_b) b_ack <= 1'b1;
          else         a_ack <= 1'b1;
        end
        DONE: begin
          a_ack    <= 1'b0;
          b_ack    <= 1'b0;
          busy     <= 1'b0;
          prefer_b <= !owner_b;
        end
        default: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model and a behavioural SRAM.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, b_ack, busy, mem_we;
  logic [7:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [6:0] mem_raddr, mem_waddr;

  sram_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, write while enabled at the clock edge
  logic [7:0] sram [128];
  assign mem_rdata = sram[mem_raddr];
  always @(posedge clk) if (mem_we) sram[mem_waddr] <= mem_wdata;

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  // Transaction-level reference model
  int         free_edge = 0;
  int         g = -10;
  logic       prefer_b = 1'b0;
  logic       t_b = 1'b0, t_we = 1'b0;
  logic [7:0] t_rd = '0;
  logic [6:0] exp_addr = '0;
  logic [7:0] exp_wd = '0, exp_ar = '0, exp_br = '0;
  logic [7:0] ref_mem [128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
  endtask

  task automatic model_edge();
    if (edge_n >= free_edge && (a_req || b_req)) begin
      t_b       = b_req && (!a_req || prefer_b);
      t_we      = t_b ? b_we : a_we;
      exp_addr  = t_b ? b_addr : a_addr;
      exp_wd    = t_b ? b_wdata : a_wdata;
      g         = edge_n;
      free_edge = edge_n + 3;
      prefer_b  = !t_b;
      if (t_we) ref_mem[exp_addr] = exp_wd;
      else      t_rd = ref_mem[exp_addr];
    end
    if (edge_n - g == 1 && !t_we) begin
      if (t_b) exp_br = t_rd;
      else     exp_ar = t_rd;
    end
  endtask

  task automatic check_all();
    int ph;
    ph = edge_n - g;
    chk("busy",      32'(busy),      32'(ph == 0 || ph == 1));
    chk("mem_we",    32'(mem_we),    32'(ph == 0 && t_we));
    chk("a_ack",     32'(a_ack),     32'(ph == 1 && !t_b));
    chk("b_ack",     32'(b_ack),     32'(ph == 1 && t_b));
    chk("a_rdata",   32'(a_rdata),   32'(exp_ar));
    chk("b_rdata",   32'(b_rdata),   32'(exp_br));
    chk("mem_waddr", 32'(mem_waddr), 32'(exp_addr));
    chk("mem_raddr", 32'(mem_raddr), 32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_a(input logic r, input logic w, input logic [6:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [6:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, 7'd0, 8'd0);
    set_b(1'b0, 1'b0, 7'd0, 8'd0);
    repeat (n) step();
  endtask

  task automatic model_reset();
    g = -10; free_edge = 0; prefer_b = 1'b0; t_we = 1'b0; t_b = 1'b0;
    exp_ar = '0; exp_br = '0; exp_addr = '0; exp_wd = '0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_we",     32'(mem_we), 32'd0);
    chk("rst_a_ack",  32'(a_ack),  32'd0);
    chk("rst_b_ack",  32'(b_ack),  32'd0);
    chk("rst_waddr",  32'(mem_waddr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single write to address 0
    set_a(1'b1, 1'b1, 7'd0, 8'h00);
    step();
    idle(3);

    // A writes FF to addr 1, B reads it back
    set_a(1'b1, 1'b1, 7'd1, 8'hFF);
    step();
    idle(2);
    set_b(1'b1, 1'b0, 7'd1, 8'h00);
    step();
    idle(3);
    chk("b_readback", 32'(b_rdata), 32'h0000_00FF);

    // Both requesters hammering address 127
    set_a(1'b1, 1'b1, 7'd127, 8'hAA);
    set_b(1'b1, 1'b1, 7'd127, 8'h55);
    repeat (12) step();
    idle(3);

    // A reads addr 1 with stray write data on the bus
    set_a(1'b1, 1'b0, 7'd1, 8'hAA);
    step();
    idle(3);
    chk("a_read_ff", 32'(a_rdata), 32'h0000_00FF);
    chk("sram1_kept", 32'(sram[1]), 32'h0000_00FF);

    // Reset in the middle of an ACCESS cycle (a read, so SRAM is untouched)
    set_a(1'b1, 1'b0, 7'd5, 8'h00);
    step();
    idle(0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we",    32'(mem_we), 32'd0);
    chk("mid_rst_busy",  32'(busy),   32'd0);
    chk("mid_rst_a_ack", 32'(a_ack),  32'd0);
    chk("mid_rst_b_ack", 32'(b_ack),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    set_a(1'b1, 1'b1, 7'd3, 8'h33);
    set_b(1'b1, 1'b1, 7'd4, 8'h44);
    step();
    chk("post_rst_grant_a", 32'(mem_waddr), 32'd3);
    repeat (5) step();
    idle(3);

    // Back-to-back requests from A
    set_a(1'b1, 1'b0, 7'd127, 8'h00);
    repeat (9) step();
    idle(3);

    // Random traffic on a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      set_a(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            7'($urandom_range(0, 7)), 8'($urandom));
      set_b(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            7'($urandom_range(0, 7)), 8'($urandom));
      step();
    end
    idle(4);

    for (int i = 0; i < 128; i++) chk("sram_final", 32'(sram[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-requester arbiter and sequencer for the 128 x 8 SRAM register file. It owns all four SRAM control inputs: read address, write address, write data and write enable. It grants one requester at a time with round-robin fairness, runs one read or one write per grant, and returns read data with a one-cycle ack pulse. It sits between the SRAM and two client blocks, for example a loader and a display scanner.

Parameters:
ADDR_W, 7, SRAM address width (128 words)
DATA_W, 8, SRAM word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
a_req  in  1  requester A wants a transaction
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  ADDR_W  A word address
a_wdata  in  DATA_W  A write data
a_ack  out  1  one-cycle pulse: A transaction complete
a_rdata  out  DATA_W  A read data, valid when a_ack = 1
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same meaning as the A ports, for requester B
busy  out  1  arbiter is not in IDLE
mem_raddr  out  ADDR_W  to SRAM ReadRegister
mem_waddr  out  ADDR_W  to SRAM WriteRegister
mem_wdata  out  DATA_W  to SRAM WriteData
mem_we  out  1  to SRAM WriteEnable
mem_rdata  in  DATA_W  from SRAM ReadData (combinational)

Behaviour:
- Outputs: all outputs are registered.
  - Reset values: a_ack, b_ack, mem_we and busy = 0. a_rdata, b_rdata, mem_raddr, mem_waddr and mem_wdata = 0.
  - The priority pointer resets to A. The FSM resets to IDLE.
- IDLE:
  - Sample a_req/b_req. If neither is set, stay in IDLE.
  - If only one is set, grant it. If both are set, grant the requester not served last.
  - On grant, latch owner, we, addr and wdata into internal registers; go to ACCESS; busy = 1 from the next cycle.
- ACCESS (one cycle):
  - mem_raddr and mem_waddr = latched addr; mem_wdata = latched wdata.
  - mem_we = 1 for exactly this cycle, and only if the latched we = 1.
  - Reads: capture mem_rdata into the owner's rdata register at the end of the cycle.
  - Go to DONE.
- DONE (one cycle):
  - mem_we = 0. Pulse the owner's ack; the non-owner's ack stays 0.
  - Update the priority pointer to the other requester. Go to IDLE.
- Address/data stability: mem addresses and mem_wdata change only on the edge entering ACCESS. mem_we is never high while the address or data is changing. This matters because the SRAM writes on a level-sensitive enable.
- Latency: a request sampled in IDLE at cycle N gets its ack in cycle N+2. Throughput is one transaction per 3 cycles.
- Write ack: a_rdata/b_rdata keep their previous value.
- rdata hold: rdata holds its value until the owner's next read completes.
- Client protocol:
  - Command fields need only be valid in the cycle req is sampled in IDLE.
  - A requester must drop req in the cycle after it sees ack, unless it wants a back-to-back transaction.
  - If req is still high when the FSM returns to IDLE, it is treated as a new request.
- Fairness: when both requesters hold req continuously, grants alternate A, B, A, B...
- Non-owner requests wait; they are never dropped.
- Same-address accesses: a write followed by a read of the same address returns the new data, because the SRAM read is combinational.
- Reset mid-operation: reset is asynchronous. The FSM goes to IDLE immediately and mem_we drops in the same instant; no ack is issued. The transaction is lost, and a write may or may not have landed in the SRAM.
- Address range: all 7-bit addresses 0..127 are legal. There is no wrap logic; the address is passed through unmodified.

Test Plan:
- Single write: reset, then a_req=1, a_we=1, a_addr=0, a_wdata=8'h00 for 1 cycle -> mem_we high exactly 1 cycle with mem_waddr=0; a_ack pulses 2 cycles after the sampling edge.
- Write/readback across requesters: A writes 8'hFF to addr 1, then B reads addr 1 -> b_rdata=8'hFF with b_ack; a_rdata unchanged.
- Simultaneous requests: a_req=b_req=1 held for 12 cycles, with A writing 8'hAA and B writing 8'h55 to addr 127 -> acks ordered A, B, A, B; mem_we never overlaps a change of address or data.
- Read only: A reads addr 1 after it holds 8'hFF, with a_wdata=8'hAA on the bus -> mem_we stays 0, a_rdata=8'hFF, SRAM contents unchanged.
- Reset during ACCESS: assert reset mid-cycle -> mem_we, acks and busy go to 0 immediately. After release, with both requests pending, A is granted first.
- Back-to-back: A holds a_req through its ack -> second transaction starts in the next IDLE; a_ack pulses every 3 cycles.
